// File: rtl/pwm_dimmer_pkg.sv
// Shared types and constants for the LED PWM dimmer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_dimmer_pkg;

    // Default count/duty width; the PWM period is 2^CW clocks.
    localparam int CW_DEF = 4;

    // Largest duty code for a given width (all ones).
    function automatic int duty_max(input int cw);
        return (1 << cw) - 1;
    endfunction

    localparam int DUTY_MAX = (1 << CW_DEF) - 1;

    // Dimmer control modes: manual buttons, or a triangle fade.
    typedef enum logic [1:0] {
        MANUAL  = 2'd0,
        FADE_UP = 2'd1,
        FADE_DN = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/pwm_dimmer_btn_debounce.sv
// Synchronize a raw bouncy button, debounce it, and emit a one-cycle press pulse.
// Latency: the press pulse appears DB_CYCLES+2 clocks after a clean rising level.
// Backpressure: none; the pulse is lost if the consumer ignores it.
module btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNTW = $clog2(DB_CYCLES + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DB_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic            press_q, press_d;

    // Count consecutive disagreeing samples; flip the level once enough accumulate.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state and registered press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pwm_dimmer.sv
// PWM dimmer: compares the period counter against a shadow duty set by buttons or a triangle fade.
// Latency: count -> pwm_out 1 clock; target duty -> active duty at the next period wrap.
// Backpressure: none; button presses during a fade are dropped.
module pwm_dimmer
    import pwm_dimmer_pkg::*;
#(
    parameter int CW           = CW_DEF,
    parameter int DB_CYCLES    = 16,
    parameter int FADE_PERIODS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] count,
    input  logic          btn_up,
    input  logic          btn_dn,
    input  logic          fade_en,
    output logic          pwm_out,
    output logic [CW-1:0] duty,
    output logic          fading
);

    localparam logic [CW-1:0] DMAX    = CW'(duty_max(CW));
    localparam logic [CW-1:0] DMAX_M1 = CW'(duty_max(CW) - 1);
    localparam logic [CW-1:0] DONE    = CW'(1);
    localparam logic [7:0]    FP_LAST = 8'(FADE_PERIODS - 1);

    logic          up_press, dn_press;
    logic          wrap;
    fsm_state_t    state_q, state_d;
    logic [CW-1:0] dt_q,    dt_d;
    logic [CW-1:0] duty_q,  duty_d;
    logic [7:0]    fcnt_q,  fcnt_d;
    logic          pwm_q,   pwm_d;
    logic          fading_q, fading_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_up),
        .press   (up_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_dn),
        .press   (dn_press)
    );

    assign wrap = (count == DMAX);

    // Mode control and target duty: manual presses, or one fade step every FADE_PERIODS wraps.
    always_comb begin
        state_d = state_q;
        dt_d    = dt_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            MANUAL: begin
                if (fade_en) begin
                    state_d = (dt_q == DMAX) ? FADE_DN : FADE_UP;
                end else if (up_press && !dn_press) begin
                    if (dt_q != DMAX) dt_d = dt_q + 1'b1;
                end else if (dn_press && !up_press) begin
                    if (dt_q != '0) dt_d = dt_q - 1'b1;
                end
            end
            FADE_UP: begin
                if (!fade_en) begin
                    state_d = MANUAL;
                    fcnt_d  = '0;
                end else if (wrap) begin
                    if (fcnt_q == FP_LAST) begin
                        fcnt_d = '0;
                        dt_d   = dt_q + 1'b1;
                        if (dt_q == DMAX_M1) state_d = FADE_DN;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            FADE_DN: begin
                if (!fade_en) begin
                    state_d = MANUAL;
                    fcnt_d  = '0;
                end else if (wrap) begin
                    if (fcnt_q == FP_LAST) begin
                        fcnt_d = '0;
                        dt_d   = dt_q - 1'b1;
                        if (dt_q == DONE) state_d = FADE_UP;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = MANUAL;
                fcnt_d  = '0;
            end
        endcase
    end

    // Shadow duty loads only on the wrap so a period never sees two duty values.
    always_comb begin
        duty_d   = wrap ? dt_q : duty_q;
        pwm_d    = (count < duty_q);
        fading_d = (state_d != MANUAL);
    end

    // All dimmer state; reset forces the output low immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MANUAL;
            dt_q     <= '0;
            duty_q   <= '0;
            fcnt_q   <= '0;
            pwm_q    <= 1'b0;
            fading_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dt_q     <= dt_d;
            duty_q   <= duty_d;
            fcnt_q   <= fcnt_d;
            pwm_q    <= pwm_d;
            fading_q <= fading_d;
        end
    end

    assign pwm_out = pwm_q;
    assign duty    = duty_q;
    assign fading  = fading_q;

endmodule

// File: tb/tb_pwm_dimmer.sv
// Self-checking bench for pwm_dimmer against a cycle-level behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_dimmer;

    localparam int CW = 4;
    localparam int DB = 16;
    localparam int FP = 2;
    localparam int TOP = 15;

    localparam int M_MAN = 0;
    localparam int M_UP  = 1;
    localparam int M_DN  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] count = '0;
    logic          btn_up = 1'b0;
    logic          btn_dn = 1'b0;
    logic          fade_en = 1'b0;
    logic          pwm_out;
    logic [CW-1:0] duty;
    logic          fading;

    int total = 0;
    int bad   = 0;

    // Model state
    int          m_dt, m_duty, m_pwm, m_mode, m_fcnt;
    logic [63:0] hist [2];
    bit          lvl  [2];
    bit          prs  [2];

    pwm_dimmer #(.CW(CW), .DB_CYCLES(DB), .FADE_PERIODS(FP)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .count   (count),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .fade_en (fade_en),
        .pwm_out (pwm_out),
        .duty    (duty),
        .fading  (fading)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // True when the last DB synchronized samples (raw delayed by two edges) all differ from lv.
    function automatic bit all_differ(input logic [63:0] h, input bit lv);
        for (int i = 1; i <= DB; i++)
            if (h[i] == lv) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_dt = 0; m_duty = 0; m_pwm = 0; m_mode = M_MAN; m_fcnt = 0;
        for (int b = 0; b < 2; b++) begin
            hist[b] = '0; lvl[b] = 1'b0; prs[b] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit wrap;
        bit up, dn, raw;
        bit nprs [2];
        wrap = (count == TOP);
        up = prs[0];
        dn = prs[1];
        for (int b = 0; b < 2; b++) begin
            raw = (b == 0) ? btn_up : btn_dn;
            nprs[b] = 1'b0;
            if (all_differ(hist[b], lvl[b])) begin
                lvl[b]  = !lvl[b];
                nprs[b] = lvl[b];
            end
            hist[b] = {hist[b][62:0], raw};
        end
        m_pwm = (int'(count) < m_duty) ? 1 : 0;
        if (wrap) m_duty = m_dt;
        if (m_mode == M_MAN) begin
            if (fade_en) m_mode = (m_dt == TOP) ? M_DN : M_UP;
            else if (up && !dn) m_dt = (m_dt < TOP) ? m_dt + 1 : TOP;
            else if (dn && !up) m_dt = (m_dt > 0) ? m_dt - 1 : 0;
        end else if (!fade_en) begin
            m_mode = M_MAN;
            m_fcnt = 0;
        end else if (wrap) begin
            if (m_fcnt == FP - 1) begin
                m_fcnt = 0;
                if (m_mode == M_UP) begin
                    m_dt++;
                    if (m_dt == TOP) m_mode = M_DN;
                end else begin
                    m_dt--;
                    if (m_dt == 0) m_mode = M_UP;
                end
            end else begin
                m_fcnt++;
            end
        end
        prs[0] = nprs[0];
        prs[1] = nprs[1];
    endtask

    // One clock: model follows the edge, outputs are compared at the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        count = count + 1'b1;
        chk("pwm_out", pwm_out, m_pwm);
        chk("duty", duty, m_duty);
        chk("fading", fading, (m_mode != M_MAN) ? 1 : 0);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic press(input bit u, input bit d);
        btn_up = u; btn_dn = d;
        run(DB + 4);
        btn_up = 1'b0; btn_dn = 1'b0;
        run(DB + 4);
    endtask

    task automatic high_count(input string tag, input int n, input int exp);
        int hi = 0;
        repeat (n) begin
            cycle();
            hi += int'(pwm_out);
        end
        chk(tag, hi, exp);
    endtask

    initial begin
        int  guard;
        bit  saw_peak, saw_zero;

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_pwm", pwm_out, 0);
        chk("reset_duty", duty, 0);
        chk("reset_fading", fading, 0);
        rst_n = 1'b1;
        run(5);

        // Manual up, three clean presses
        repeat (3) press(1'b1, 1'b0);
        run(20);
        chk("duty_after_3_up", duty, 3);
        high_count("pwm_high_duty3", 16, 3);

        // Bounce must not register; saturation at both ends
        repeat (20) begin
            btn_dn = !btn_dn;
            run(5);
        end
        btn_dn = 1'b0;
        run(20);
        chk("bounce_no_event", duty, 3);
        repeat (4) press(1'b0, 1'b1);
        run(20);
        chk("dn_saturate", duty, 0);
        high_count("pwm_high_duty0", 16, 0);
        repeat (16) press(1'b1, 1'b0);
        run(20);
        chk("up_saturate", duty, 15);
        high_count("pwm_high_duty15", 16, 15);

        // Simultaneous presses cancel
        press(1'b1, 1'b1);
        run(20);
        chk("both_buttons", duty, 15);
        press(1'b0, 1'b1);
        run(20);
        chk("duty_14", duty, 14);

        // Triangle fade from 14 up to 15, down to 0, up to 9
        fade_en = 1'b1;
        cycle();
        chk("fading_on", fading, 1);
        guard = 0; saw_peak = 0; saw_zero = 0;
        while (guard < 3000 && !(saw_zero && m_mode == M_UP && m_dt == 9)) begin
            btn_up = 1'($urandom % 2);
            btn_dn = 1'($urandom % 2);
            cycle();
            if (duty == 4'd15) saw_peak = 1;
            if (saw_peak && duty == 4'd0) saw_zero = 1;
            guard++;
        end
        if (guard >= 3000) chk("fade_sweep_timeout", 0, 1);
        chk("fade_peak_seen", saw_peak, 1);
        chk("fade_zero_seen", saw_zero, 1);
        btn_up = 1'b0; btn_dn = 1'b0;
        fade_en = 1'b0;
        cycle();
        chk("fading_off", fading, 0);
        run(40);
        chk("fade_hold_9", duty, 9);

        // Asynchronous reset in mid-period
        guard = 0;
        while (count != 4'd5 && guard < 32) begin
            cycle();
            guard++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm", pwm_out, 0);
        chk("async_rst_duty", duty, 0);
        chk("async_rst_fading", fading, 0);
        cycle();
        rst_n = 1'b1;
        high_count("pwm_low_after_rst", 32, 0);

        // Randomized mix of buttons and fade
        repeat (80) begin
            btn_up  = ($urandom % 3) == 0;
            btn_dn  = ($urandom % 4) == 0;
            fade_en = ($urandom % 5) == 0;
            run($urandom_range(1, 40));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
